// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined add/subtract/accumulate unit:
// operation encodings and an elaboration-time parameter sanity check.
package pipe_add_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_LDA = 2'b11
  } op_e;

  // True when the parameter set is legal: the result must hold the full
  // WIDTH+1 bit sum, and the operand must split evenly into segments.
  function automatic bit params_ok(input int width, input int out_width, input int segs);
    return (segs > 0) && (width > 0) && (out_width >= width + 1) && ((width % segs) == 0);
  endfunction

endpackage

// File: rtl/pipe_add_seg.sv
// Combinational SEG_W-bit ripple-carry adder segment with carry in/out.
module pipe_add_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  logic carry;

  // Bit-serial ripple through the segment.
  always_comb begin
    sum   = '0;
    carry = cin;
    for (int i = 0; i < SEG_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipe_add_unit.sv
// Pipelined add/subtract/accumulate unit. The WIDTH-bit add is cut into
// SEGS ripple segments, one register stage each, with the carry registered
// between stages. A final stage applies the op, updates the accumulator
// and registers Result. A single global enable stalls the whole pipe.
module pipe_add_unit
  import pipe_add_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 40,
  parameter int SEGS      = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [1:0]           Op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] Result,
  output logic                 out_ovf
);

  localparam int SEG_W = WIDTH / SEGS;
  localparam int EXT_W = OUT_WIDTH - WIDTH;

  if (!params_ok(WIDTH, OUT_WIDTH, SEGS)) begin : g_param_err
    $error("pipe_add_unit: need OUT_WIDTH >= WIDTH+1 and WIDTH divisible by SEGS");
  end

  // Stage s (0..SEGS) holds the operands, the partial sum with the lower
  // s segments filled in, and the carry into segment s.
  logic [WIDTH-1:0] a_q   [0:SEGS];
  logic [WIDTH-1:0] b_q   [0:SEGS];
  logic [WIDTH-1:0] sum_q [0:SEGS];
  logic [WIDTH-1:0] sum_nxt [1:SEGS];
  op_e              op_q  [0:SEGS];
  logic [SEGS:0]    cy_q;
  logic [SEGS:0]    vld_q;

  logic [SEGS-1:0][SEG_W-1:0] seg_sum;
  logic [SEGS-1:0]            seg_cout;

  logic                 en;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] sum_ext;
  logic [OUT_WIDTH:0]   acc_sum;
  op_e                  op_in;

  // Whole pipe advances whenever the output register is free or draining.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign op_in    = op_e'(Op);

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    pipe_add_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a   (a_q[k][k*SEG_W +: SEG_W]),
      .b   (b_q[k][k*SEG_W +: SEG_W]),
      .cin (cy_q[k]),
      .sum (seg_sum[k]),
      .cout(seg_cout[k])
    );
  end

  // Merge each segment's fresh sum bits into the partial sum passed down.
  always_comb begin
    for (int k = 1; k <= SEGS; k++) begin
      sum_nxt[k] = sum_q[k-1];
      sum_nxt[k][(k-1)*SEG_W +: SEG_W] = seg_sum[k-1];
    end
  end

  // Operand capture and segment pipeline registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      for (int s = 0; s <= SEGS; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        op_q[s]  <= OP_ADD;
      end
      cy_q  <= '0;
      vld_q <= '0;
    end else if (en) begin
      // Subtraction is A + ~B + 1; the +1 rides in as the first carry.
      a_q[0]   <= A;
      b_q[0]   <= (op_in == OP_SUB) ? ~B : B;
      sum_q[0] <= '0;
      op_q[0]  <= op_in;
      cy_q[0]  <= (op_in == OP_SUB);
      vld_q[0] <= in_valid;
      for (int s = 1; s <= SEGS; s++) begin
        a_q[s]   <= a_q[s-1];
        b_q[s]   <= b_q[s-1];
        sum_q[s] <= sum_nxt[s];
        op_q[s]  <= op_q[s-1];
        cy_q[s]  <= seg_cout[s-1];
        vld_q[s] <= vld_q[s-1];
      end
    end
  end

  // Extend the finished sum: signed for SUB (negative iff no carry out),
  // zero-extended otherwise; also form the wide accumulate sum.
  always_comb begin
    sum_ext = '0;
    if (op_q[SEGS] == OP_SUB) begin
      sum_ext = {{EXT_W{~cy_q[SEGS]}}, sum_q[SEGS]};
    end else begin
      sum_ext[WIDTH:0] = {cy_q[SEGS], sum_q[SEGS]};
    end
    acc_sum = {1'b0, acc_q} + {1'b0, sum_ext};
  end

  // Final stage: apply the op, update the accumulator, register the result.
  always_ff @(posedge clk) begin
    if (RST) begin
      out_valid <= 1'b0;
      Result    <= '0;
      out_ovf   <= 1'b0;
      acc_q     <= '0;
    end else if (en) begin
      out_valid <= vld_q[SEGS];
      if (vld_q[SEGS]) begin
        case (op_q[SEGS])
          OP_ADD, OP_SUB: begin
            Result  <= sum_ext;
            out_ovf <= 1'b0;
          end
          OP_LDA: begin
            acc_q   <= sum_ext;
            Result  <= sum_ext;
            out_ovf <= 1'b0;
          end
          OP_ACC: begin
            acc_q   <= acc_sum[OUT_WIDTH-1:0];
            Result  <= acc_sum[OUT_WIDTH-1:0];
            out_ovf <= acc_sum[OUT_WIDTH];
          end
          default: begin
            Result  <= sum_ext;
            out_ovf <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_add_unit.sv
// Directed bench for pipe_add_unit: main instance with SEGS=4 plus SEGS=1
// and SEGS=8 instances sharing clock and reset.
module tb_pipe_add_unit;
  import pipe_add_pkg::*;

  localparam int W  = 32;
  localparam int OW = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          RST;
  logic          in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [W-1:0]  A, B;
  logic [1:0]    Op;
  logic [OW-1:0] Result;

  logic          s_valid;
  logic [W-1:0]  s_a, s_b;
  logic [1:0]    s_op;
  logic          s1_in_ready, s1_out_valid, s1_out_ovf;
  logic          s8_in_ready, s8_out_valid, s8_out_ovf;
  logic [OW-1:0] s1_result, s8_result;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_add_unit #(.WIDTH(W), .OUT_WIDTH(OW), .SEGS(4)) dut (
    .clk(clk), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Op(Op), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .out_ovf(out_ovf)
  );

  pipe_add_unit #(.WIDTH(W), .OUT_WIDTH(OW), .SEGS(1)) dut_s1 (
    .clk(clk), .RST(RST), .in_valid(s_valid), .in_ready(s1_in_ready),
    .A(s_a), .B(s_b), .Op(s_op), .out_valid(s1_out_valid), .out_ready(1'b1),
    .Result(s1_result), .out_ovf(s1_out_ovf)
  );

  pipe_add_unit #(.WIDTH(W), .OUT_WIDTH(OW), .SEGS(8)) dut_s8 (
    .clk(clk), .RST(RST), .in_valid(s_valid), .in_ready(s8_in_ready),
    .A(s_a), .B(s_b), .Op(s_op), .out_valid(s8_out_valid), .out_ready(1'b1),
    .Result(s8_result), .out_ovf(s8_out_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One beat into the main instance; checks latency, Result and out_ovf.
  task automatic send_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OW-1:0] exp_res, input logic exp_ovf, input string tag);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; Op = op; A = a; B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd5);
    check({tag, " result"}, 64'(Result), 64'(exp_res));
    check({tag, " ovf"}, 64'(out_ovf), 64'(exp_ovf));
  endtask

  // One beat into both sweep instances; checks each latency and value.
  task automatic sweep_one(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [OW-1:0] exp_res, input string tag);
    int l1, l8;
    logic [OW-1:0] r1, r8;
    logic o1, o8;
    l1 = -1; l8 = -1; r1 = '0; r8 = '0; o1 = 1'b0; o8 = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_op = op; s_a = a; s_b = b;
    #1;
    check({tag, " in_ready"}, 64'({s1_in_ready, s8_in_ready}), 64'd3);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (s1_out_valid && l1 < 0) begin l1 = c; r1 = s1_result; o1 = s1_out_ovf; end
      if (s8_out_valid && l8 < 0) begin l8 = c; r8 = s8_result; o8 = s8_out_ovf; end
      @(posedge clk); #1;
    end
    check({tag, " segs1 latency"}, 64'(l1), 64'd2);
    check({tag, " segs8 latency"}, 64'(l8), 64'd9);
    check({tag, " segs1 result"}, 64'(r1), 64'(exp_res));
    check({tag, " segs8 result"}, 64'(r8), 64'(exp_res));
    check({tag, " segs1 ovf"}, 64'(o1), 64'd0);
    check({tag, " segs8 ovf"}, 64'(o8), 64'd0);
  endtask

  initial begin
    int sent, got, cyc, stalls, seen;
    logic [OW-1:0] last;
    logic ovf_seen;

    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Op = OP_ADD;
    s_valid = 1'b0; s_a = '0; s_b = '0; s_op = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(Result), 64'd0);
    check("reset ovf", 64'(out_ovf), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    RST = 1'b0;

    // Carry ripples through all four segments; then both SUB signs.
    send_one(OP_ADD, 32'hFFFF_FFFF, 32'h1, 40'h01_0000_0000, 1'b0, "add carry");
    send_one(OP_SUB, 32'd5, 32'd7, 40'hFF_FFFF_FFFE, 1'b0, "sub neg");
    send_one(OP_SUB, 32'd7, 32'd5, 40'h00_0000_0002, 1'b0, "sub pos");

    // Load, then 127 back-to-back accumulates, then the wrapping one.
    send_one(OP_LDA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h01_FFFF_FFFE, 1'b0, "lda");
    sent = 0; got = 0; cyc = 0; ovf_seen = 1'b0; last = '0;
    while (got < 127 && cyc < 400) begin
      @(posedge clk); #1;
      if (out_valid) begin
        got++;
        last = Result;
        ovf_seen = ovf_seen | out_ovf;
      end
      in_valid = (sent < 127);
      Op = OP_ACC; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      if (in_valid) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    check("acc stream count", 64'(got), 64'd127);
    check("acc stream last", 64'(last), 64'hFF_FFFF_FF00);
    check("acc stream ovf", 64'(ovf_seen), 64'd0);
    send_one(OP_ACC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h01_FFFF_FEFE, 1'b1, "acc wrap");

    // Backpressure: 10 ADD beats with a three-cycle output stall.
    sent = 0; got = 0; cyc = 0; stalls = 0;
    while (got < 10 && cyc < 100) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 7 && cyc <= 9);
      in_valid  = (sent < 10);
      Op = OP_ADD; A = W'(sent); B = W'(sent);
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        check("bp in_ready low", 64'(in_ready), 64'd0);
        check("bp result held", 64'(Result), 64'(2 * got));
      end
      if (out_valid && out_ready) begin
        check("bp result", 64'(Result), 64'(2 * got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp count", 64'(got), 64'd10);
    check("bp stall cycles", 64'(stalls), 64'd3);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("bp no extra beat", 64'(seen), 64'd0);

    // Reset with the pipe full of ACC beats.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; Op = OP_ACC; A = 32'd3; B = 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(Result), 64'd0);
    check("rst ovf", 64'(out_ovf), 64'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst no stale beat", 64'(seen), 64'd0);
    send_one(OP_ACC, 32'd1, 32'd0, 40'h1, 1'b0, "acc after rst");

    // Segment-count sweep, same directed sequence into SEGS=1 and SEGS=8.
    sweep_one(OP_LDA, 32'd10, 32'd5, 40'hF, "sw lda");
    sweep_one(OP_ACC, 32'd1, 32'd2, 40'h12, "sw acc");
    sweep_one(OP_ADD, 32'h8000_0000, 32'h8000_0000, 40'h01_0000_0000, "sw add");
    sweep_one(OP_SUB, 32'd0, 32'd1, 40'hFF_FFFF_FFFF, "sw sub neg");
    sweep_one(OP_ACC, 32'hFFFF_FFFF, 32'd0, 40'h01_0000_0011, "sw acc2");
    sweep_one(OP_SUB, 32'h1234_5678, 32'h0234_5678, 40'h00_1000_0000, "sw sub pos");
    sweep_one(OP_ACC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h03_0000_000F, "sw acc3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
